// File: rtl/atan_cordic_pkg.sv
// rtl/atan_cordic_pkg.sv - shared types and widths for the CORDIC arctangent core
package atan_cordic_pkg;
  localparam int DATA_W  = 16;
  localparam int GUARD_W = 2;
  localparam int XY_W    = 21;
  localparam int Z_W     = 20;
  localparam int ROM_W   = 18;
  localparam int IDX_W   = 5;

  localparam logic signed [XY_W-1:0] ONE_Q18 = 21'sh40000;

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;
endpackage

// File: rtl/atan_cordic_if.sv
// rtl/atan_cordic_if.sv - start/busy/ready control bus shared with the tan core
interface atan_cordic_if;
  import atan_cordic_pkg::*;

  logic              start;
  logic [DATA_W-1:0] t;
  logic              busy;
  logic              ready;
  logic [DATA_W-1:0] angle;

  modport master (output start, t, input busy, ready, angle);
  modport slave  (input start, t, output busy, ready, angle);
endinterface

// File: rtl/atan_rom.sv
// rtl/atan_rom.sv - elementary angles atan(2^-i) in Q0.18, zero past the table end
module atan_rom
  import atan_cordic_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [ROM_W-1:0] a
);
  always_comb begin
    a = '0;
    case (idx)
      5'd0:    a = 18'd205887;
      5'd1:    a = 18'd121542;
      5'd2:    a = 18'd64220;
      5'd3:    a = 18'd32599;
      5'd4:    a = 18'd16363;
      5'd5:    a = 18'd8189;
      5'd6:    a = 18'd4096;
      5'd7:    a = 18'd2048;
      5'd8:    a = 18'd1024;
      5'd9:    a = 18'd512;
      5'd10:   a = 18'd256;
      5'd11:   a = 18'd128;
      5'd12:   a = 18'd64;
      5'd13:   a = 18'd32;
      5'd14:   a = 18'd16;
      5'd15:   a = 18'd8;
      5'd16:   a = 18'd4;
      5'd17:   a = 18'd2;
      default: a = '0;
    endcase
  end
endmodule

// File: rtl/atan_cordic.sv
// rtl/atan_cordic.sv - iterative CORDIC vectoring arctangent, Q0.16 in and out
module atan_cordic
  import atan_cordic_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic          clk,
  input  logic          rst,
  atan_cordic_if.slave  bus
);
  state_t                   state, state_nx;
  logic                     start_d;
  logic signed [XY_W-1:0]   x, y;
  logic signed [Z_W-1:0]    z;
  logic [IDX_W-1:0]         i;
  logic [DATA_W-1:0]        angle_q;

  logic                     req, accept, last;
  logic [ROM_W-1:0]         a_i;
  logic signed [Z_W-1:0]    a_ext;
  logic signed [XY_W-1:0]   x_sh, y_sh;
  logic signed [Z_W:0]      z_rnd, z_q;
  logic [DATA_W-1:0]        angle_nx;

  atan_rom u_rom (.idx(i), .a(a_i));

  assign req    = bus.start & ~start_d;
  assign accept = req & ((state == IDLE) || (state == DONE));
  assign last   = (i == IDX_W'(ITER - 1));
  assign a_ext  = signed'({{(Z_W-ROM_W){1'b0}}, a_i});
  assign x_sh   = x >>> i;
  assign y_sh   = y >>> i;

  // Round Q1.18 to Q0.16; negative residue (t near 0) clamps to zero.
  assign z_rnd  = {z[Z_W-1], z} + 21'sd2;
  assign z_q    = z_rnd >>> GUARD_W;
  always_comb begin
    angle_nx = z_q[DATA_W-1:0];
    if (z[Z_W-1])
      angle_nx = '0;
    else if (z_q[Z_W:DATA_W] != '0)
      angle_nx = '1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (accept) state_nx = RUN;
      RUN:        if (last) state_nx = FINISH;
      FINISH:     state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_d <= 1'b0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      angle_q <= '0;
    end else begin
      start_d <= bus.start;
      if (accept) begin
        x <= ONE_Q18;
        y <= signed'({{(XY_W-DATA_W-GUARD_W){1'b0}}, bus.t, {GUARD_W{1'b0}}});
        z <= '0;
        i <= '0;
      end else if (state == RUN) begin
        if (!y[XY_W-1]) begin
          x <= x + y_sh;
          y <= y - x_sh;
          z <= z + a_ext;
        end else begin
          x <= x - y_sh;
          y <= y + x_sh;
          z <= z - a_ext;
        end
        i <= i + 1'b1;
      end else if (state == FINISH) begin
        angle_q <= angle_nx;
      end
    end
  end

  assign bus.busy  = (state == RUN) || (state == FINISH);
  assign bus.ready = (state == DONE);
  assign bus.angle = angle_q;
endmodule

// File: tb/tb_atan_cordic.sv
// tb/tb_atan_cordic.sv - directed and swept checks of the CORDIC arctangent core
module tb_atan_cordic;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atan_cordic_if bus ();
  atan_cordic #(.ITER(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.busy && bus.ready) begin
        errors++;
        $display("FAIL exclusive busy=%0b ready=%0b required not both high", bus.busy, bus.ready);
      end
    end
  end

  task automatic pulse(input logic [15:0] tv);
    @(negedge clk);
    bus.t = tv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    while (!bus.ready && guard < 100) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!bus.ready) begin
      errors++;
      $display("FAIL timeout ready=%0b required 1 within 100 cycles", bus.ready);
    end
  endtask

  task automatic test_reset();
    int nb, d;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.t = '0;
    #1;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.ready); end
    if (bus.angle !== 16'h0000) begin errors++; $display("FAIL reset_angle got %h want 0000", bus.angle); end
    @(negedge clk);
    rst = 1'b0;
    pulse(16'h8000);
    wait_done(nb);
    pulse(16'h4000);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", bus.busy); end
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %0b want 0", bus.ready); end
    if (bus.angle !== 16'h0000) begin errors++; $display("FAIL abort_angle got %h want 0000", bus.angle); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", bus.busy); end
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b want 0", bus.ready); end
    pulse(16'h8000);
    wait_done(nb);
    d = int'(bus.angle) - 30386;
    if (d < 0) d = -d;
    checks += 2;
    if (d > 3) begin errors++; $display("FAIL post_reset_angle got %h want 76b2+-3", bus.angle); end
    if (nb != 17) begin errors++; $display("FAIL post_reset_latency got %0d want 17", nb); end
  endtask

  task automatic test_zero();
    int nb;
    pulse(16'h0000);
    wait_done(nb);
    checks += 2;
    if (nb != 17) begin errors++; $display("FAIL zero_latency got %0d want 17", nb); end
    if (bus.angle !== 16'h0000) begin errors++; $display("FAIL zero_angle got %h want 0000", bus.angle); end
  endtask

  task automatic test_held_start();
    int busy_cnt, rises, d;
    logic prev;
    busy_cnt = 0;
    rises = 0;
    prev = 1'b0;
    @(negedge clk);
    bus.t = 16'h6A0A;
    bus.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.ready && !prev) rises++;
      prev = bus.ready;
      if (c == 4) bus.start = 1'b0;
    end
    d = int'(bus.angle) - 16'h6488;
    if (d < 0) d = -d;
    checks += 3;
    if (rises != 1) begin errors++; $display("FAIL held_ready_rises got %0d want 1", rises); end
    if (busy_cnt != 17) begin errors++; $display("FAIL held_busy_cycles got %0d want 17", busy_cnt); end
    if (d > 3) begin errors++; $display("FAIL held_angle got %h want 6488+-3", bus.angle); end
  endtask

  task automatic test_operand_range();
    int nb, d;
    pulse(16'h8000);
    repeat (3) @(negedge clk);
    bus.t = 16'h1234;
    wait_done(nb);
    d = int'(bus.angle) - 16'h76B2;
    if (d < 0) d = -d;
    checks++;
    if (d > 3) begin errors++; $display("FAIL half_angle got %h want 76b2+-3", bus.angle); end
    pulse(16'hFFFF);
    wait_done(nb);
    d = int'(bus.angle) - 16'hC90F;
    if (d < 0) d = -d;
    checks++;
    if (d > 3) begin errors++; $display("FAIL max_angle got %h want c90f+-3", bus.angle); end
  endtask

  task automatic test_back_to_back();
    int nb, d;
    pulse(16'h6A0A);
    repeat (4) @(negedge clk);
    pulse(16'h1000);
    wait_done(nb);
    repeat (25) @(negedge clk);
    d = int'(bus.angle) - 16'h6488;
    if (d < 0) d = -d;
    checks += 2;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL busy_req_ready got %0b want 1", bus.ready); end
    if (d > 3) begin errors++; $display("FAIL busy_req_angle got %h want 6488+-3", bus.angle); end
    pulse(16'h8000);
    checks += 2;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL done_req_ready got %0b want 0", bus.ready); end
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL done_req_busy got %0b want 1", bus.busy); end
    wait_done(nb);
    d = int'(bus.angle) - 16'h76B2;
    if (d < 0) d = -d;
    checks++;
    if (d > 3) begin errors++; $display("FAIL done_req_angle got %h want 76b2+-3", bus.angle); end
    // Second rising edge lands on the FINISH edge and must be dropped.
    pulse(16'h2000);
    repeat (16) @(negedge clk);
    bus.t = 16'hFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (25) @(negedge clk);
    d = int'(bus.angle) - 16'h1FD6;
    if (d < 0) d = -d;
    checks += 2;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL finish_req_ready got %0b want 1", bus.ready); end
    if (d > 3) begin errors++; $display("FAIL finish_req_angle got %h want 1fd6+-3", bus.angle); end
  endtask

  task automatic test_sweep();
    int nb, d, expv;
    logic [15:0] tv;
    for (int n = 0; n < 1000; n++) begin
      tv = 16'($urandom_range(0, 65535));
      pulse(tv);
      wait_done(nb);
      expv = int'($atan(real'(tv) / 65536.0) * 65536.0);
      d = int'(bus.angle) - expv;
      if (d < 0) d = -d;
      checks++;
      if (d > 3) begin
        errors++;
        $display("FAIL sweep t=%h got %h want %h+-3", tv, bus.angle, expv[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_held_start();
    test_operand_range();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/atan_cordic.md
# atan_cordic

Iterative arctangent unit, the inverse of the existing tan datapath: takes an unsigned fractional tangent value and returns its angle in radians using CORDIC vectoring mode. It shares the same start/busy/ready handshake and Q0.16 number format, so it can sit beside the tan core on the same control bus. The two cores can also be chained tan→atan for round-trip self-checks.

## Interface
- ITER, 16: number of CORDIC micro-rotations (1..18).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request. Only a rising edge (start high, previous-cycle start low) is a request.
- t  in  16  tangent operand, unsigned Q0.16 (value = t·2^-16, range [0,1)).
- busy  out  1  high while a computation is in progress.
- ready  out  1  high when angle holds a valid result. Stays high until the next accepted request or reset.
- angle  out  16  atan(t), unsigned Q0.16 radians; maximum is about 0xC90F (π/4).

## Operation
- Registers:
  - start_d (start delayed one cycle).
  - X, Y: signed 21-bit, Q2.18 (1 sign, 2 integer, 18 fraction).
  - Z: signed 20-bit, Q1.18.
  - i: iteration counter.
  - angle register and state.
- States:
  - IDLE: reset state, or after reset; waiting.
  - RUN: iterating.
  - FINISH: rounding and output.
  - DONE: result held.
- Request = start & ~start_d.
  - Accepted in IDLE and DONE.
  - Ignored in RUN and FINISH; no queuing.
- On an accepted request:
  - X ← 1.0 (0x40000).
  - Y ← {t, 2'b00}.
  - Z ← 0.
  - i ← 0.
  - ready ← 0, busy ← 1.
  - → RUN. t is captured here; later changes to t are ignored.
- RUN, each cycle:
  - If Y ≥ 0: X ← X + (Y>>>i), Y ← Y − (X>>>i), Z ← Z + A[i].
  - Else: X ← X − (Y>>>i), Y ← Y + (X>>>i), Z ← Z − A[i].
  - Shifts are arithmetic. Both updates use the old X and Y.
  - i ← i+1. When i = ITER−1 the state moves to FINISH.
- A[i] = round(atan(2^-i)·2^18), unsigned 18-bit constants (A[0]=205887).
- FINISH:
  - angle ← (Z + 2) >>> 2, which rounds Z to Q0.16.
  - If Z < 0, angle ← 0. This clamp covers t=0, where residual oscillation can go negative.
  - Result is saturated to 0xFFFF (never reached in practice).
  - busy ← 0, ready ← 1, → DONE.
- The CORDIC gain cancels in vectoring mode; no gain compensation is applied.
- Accuracy: |angle − round(atan(t·2^-16)·2^16)| ≤ 3 LSB for every t when ITER=16.

## Timing
- Reset values: busy=0, ready=0, angle=0x0000, state=IDLE, start_d=0, X=Y=Z=i=0.
- Reset mid-computation aborts immediately, with the same values as above. No result is produced.
- Request seen at clock edge k:
  - busy is high after edge k.
  - The last iteration happens at edge k+ITER.
  - angle is valid, ready=1 and busy=0 after edge k+ITER+1 (17 cycles for ITER=16).
- busy and ready are never both high. Both are low only in IDLE.
- angle is stable throughout DONE. It keeps its old value during RUN (not cleared) and changes only at FINISH.
- start held high for many cycles gives exactly one computation. It must go low and rise again to trigger another.
- A request in the same cycle that FINISH completes is ignored, because the state is not yet DONE.

## Structure
- Package atan_cordic_pkg holds:
  - state enum {IDLE, RUN, FINISH, DONE};
  - width constants (data 16, guard 2, X/Y 21, Z 20);
  - the constant ONE_Q18 = 0x40000.
- Sub-module atan_rom: combinational, 5-bit index in, 18-bit A[i] out. It contains a case table for i=0..17 and returns 0 for i>17.
- Top level is atan_cordic: FSM, counter, X/Y/Z datapath and output rounding.

## Test plan
- Reset check:
  - Assert rst mid-RUN.
  - Required: busy=0, ready=0, angle=0x0000 immediately, with no clock needed.
  - After release, a new request completes normally.
- t=0x0000, start pulse → ready after 17 cycles, angle=0x0000 (clamp path).
- t=0x6A0A (tan π/8), start held 5 cycles:
  - Required: angle=0x6488 ±3.
  - Exactly one ready assertion.
  - busy high for exactly 17 cycles.
- t=0x8000 (0.5) → angle=0x76B2 ±3. Change t during RUN → result unchanged.
- t=0xFFFF → angle=0xC90F ±3, no wrap or overflow.
- Back-to-back and ignored requests:
  - Pulse start while busy → ignored.
  - Pulse start in DONE → ready drops on the next edge and a new result follows.
- Sweep: 1000 random t values, each checked against a real-valued atan model to within ±3 LSB.
